com_frame_divider: RTL and testbench

- Sits directly downstream of the per-frame colour accumulators in the centre-of-mass tracker.
- Latches the frame's x-weighted, y-weighted and mass totals at each frame boundary.
- Computes xTotal/mass and yTotal/mass with a serial restoring divider, one quotient bit per cycle, then presents a stable 10-bit centre for the whole next frame.
- Replaces the vendor divider cores. The 30 Hz result rate leaves more than 70 cycles per frame available.

---
 rtl/com_frame_divider.sv | 162 ++++++++++++++++
 tb/tb_com_frame_divider.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/com_frame_divider.sv
// Centre-of-mass divider: latches per-frame totals on frame_start and computes
// x_total/mass and y_total/mass with a shared serial restoring divider.
module com_frame_divider #(
  parameter int unsigned NUM_W    = 35,
  parameter int unsigned DEN_W    = 26,
  parameter int unsigned OUT_W    = 10,
  parameter int unsigned MIN_MASS = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic [NUM_W-1:0] x_total,
  input  logic [NUM_W-1:0] y_total,
  input  logic [DEN_W-1:0] mass_total,
  output logic [OUT_W-1:0] x_center,
  output logic [OUT_W-1:0] y_center,
  output logic             center_valid,
  output logic             result_stb,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned CntW = $clog2(NUM_W);
  localparam logic [CntW-1:0] CntLast = CntW'(NUM_W - 1);
  localparam logic [DEN_W-1:0] MinMass = DEN_W'(MIN_MASS);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StDivX = 2'd1;
  localparam logic [1:0] StDivY = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [NUM_W-1:0] ytot_q, ytot_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [DEN_W:0]   rem_q, rem_d;
  logic [NUM_W-1:0] quo_q, quo_d;
  logic [NUM_W-1:0] xquo_q, xquo_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0] xc_q, xc_d, yc_q, yc_d;
  logic             valid_q, valid_d, stb_q, stb_d, busy_q, busy_d;

  logic [DEN_W:0]   rem_sh, rem_nx;
  logic             take;
  logic [NUM_W-1:0] quo_nx;

  function automatic logic [OUT_W-1:0] sat(input logic [NUM_W-1:0] q);
    if (|q[NUM_W-1:OUT_W]) return '1;
    return q[OUT_W-1:0];
  endfunction

  // One restoring step; rem_q < den_q always holds, so its MSB is zero.
  always_comb begin
    rem_sh = {rem_q[DEN_W-1:0], num_q[NUM_W-1]};
    take   = (rem_sh >= {1'b0, den_q});
    rem_nx = take ? (rem_sh - {1'b0, den_q}) : rem_sh;
    quo_nx = {quo_q[NUM_W-2:0], take};
  end

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    ytot_d  = ytot_q;
    den_d   = den_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    xquo_d  = xquo_q;
    cnt_d   = cnt_q;
    xc_d    = xc_q;
    yc_d    = yc_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    stb_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          num_d  = x_total;
          ytot_d = y_total;
          den_d  = mass_total;
          if (mass_total < MinMass) begin
            valid_d = 1'b0;
            stb_d   = 1'b1;
          end else begin
            state_d = StDivX;
            busy_d  = 1'b1;
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      StDivX, StDivY: begin
        num_d = {num_q[NUM_W-2:0], 1'b0};
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (state_q == StDivX) begin
            xquo_d  = quo_nx;
            num_d   = ytot_q;
            rem_d   = '0;
            quo_d   = '0;
            state_d = StDivY;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        xc_d    = sat(xquo_q);
        yc_d    = sat(quo_q);
        valid_d = 1'b1;
        stb_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      num_q   <= '0;
      ytot_q  <= '0;
      den_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      xquo_q  <= '0;
      cnt_q   <= '0;
      xc_q    <= '0;
      yc_q    <= '0;
      valid_q <= 1'b0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      ytot_q  <= ytot_d;
      den_q   <= den_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      xquo_q  <= xquo_d;
      cnt_q   <= cnt_d;
      xc_q    <= xc_d;
      yc_q    <= yc_d;
      valid_q <= valid_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
    end
  end

  assign x_center     = xc_q;
  assign y_center     = yc_q;
  assign center_valid = valid_q;
  assign result_stb   = stb_q;
  assign busy         = busy_q;
  // DONE counts as busy, so a frame_start there is dropped too.
  assign overrun      = frame_start & (state_q != StIdle) & ~reset;

endmodule

// File: tb/tb_com_frame_divider.sv
// Directed bench for com_frame_divider: latency, truncation, saturation,
// mass rejection, overrun and mid-division reset.
module tb_com_frame_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic [34:0] x_total, y_total;
  logic [25:0] mass_total;
  logic [9:0]  x_center, y_center;
  logic        center_valid, result_stb, busy, overrun;

  int checks = 0;
  int errors = 0;
  int lat, ovr_seen, busy_err, stb_cnt;

  always #5 clk = ~clk;

  com_frame_divider dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .x_total      (x_total),
    .y_total      (y_total),
    .mass_total   (mass_total),
    .x_center     (x_center),
    .y_center     (y_center),
    .center_valid (center_valid),
    .result_stb   (result_stb),
    .busy         (busy),
    .overrun      (overrun)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulses frame_start (sampled at edge "cycle 0"), then watches cycles 1.. for result_stb.
  // Optionally fires a second frame_start at cycle ovr_cyc and records overrun.
  task automatic run_frame(input logic [34:0] xt, input logic [34:0] yt, input logic [25:0] m,
                           input int ovr_cyc, input int busy_until,
                           output int lat_o, output int ovr_o, output int berr_o);
    lat_o = -1;
    ovr_o = 0;
    berr_o = 0;
    @(negedge clk);
    frame_start = 1'b1;
    x_total = xt;
    y_total = yt;
    mass_total = m;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      frame_start = 1'b0;
      if (busy !== logic'(n <= busy_until)) berr_o++;
      if (result_stb === 1'b1) begin
        lat_o = n;
        break;
      end
      if (n == ovr_cyc) begin
        frame_start = 1'b1;
        x_total = '1;
        y_total = 35'd12345;
        mass_total = 26'd200;
        #1 ovr_o = int'(overrun);
      end
    end
  endtask

  task automatic count_stb(input int cycles, output int cnt);
    cnt = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (result_stb === 1'b1) cnt++;
    end
  endtask

  initial begin
    reset = 1'b1;
    frame_start = 1'b0;
    x_total = '0;
    y_total = '0;
    mass_total = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_x", x_center, 0);
    chk("rst_y", y_center, 0);
    chk("rst_valid", center_valid, 0);
    chk("rst_stb", result_stb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);

    // Truncation
    run_frame(35'd1003, 35'd767, 26'd1000, -1, 71, lat, ovr_seen, busy_err);
    chk("trunc_lat", lat, 72);
    chk("trunc_busy", busy_err, 0);
    chk("trunc_x", x_center, 1);
    chk("trunc_y", y_center, 0);
    chk("trunc_valid", center_valid, 1);

    // Saturation: 2000 -> 1023
    run_frame(35'd200000, 35'd5000, 26'd100, -1, 71, lat, ovr_seen, busy_err);
    chk("sat_lat", lat, 72);
    chk("sat_x", x_center, 1023);
    chk("sat_y", y_center, 50);

    run_frame(35'd51200, 35'd30000, 26'd100, -1, 71, lat, ovr_seen, busy_err);
    chk("basic_lat", lat, 72);
    chk("basic_busy", busy_err, 0);
    chk("basic_x", x_center, 512);
    chk("basic_y", y_center, 300);
    chk("basic_valid", center_valid, 1);
    @(negedge clk);
    chk("basic_stb_pulse", result_stb, 0);
    chk("basic_hold_x", x_center, 512);

    // Mass just below threshold: rejected, centres held
    run_frame(35'd6400, 35'd6400, 26'd63, -1, 0, lat, ovr_seen, busy_err);
    chk("rej63_lat", lat, 1);
    chk("rej63_busy", busy_err, 0);
    chk("rej63_valid", center_valid, 0);
    chk("rej63_x", x_center, 512);
    chk("rej63_y", y_center, 300);

    run_frame(35'd5120, 35'd3000, 26'd10, -1, 0, lat, ovr_seen, busy_err);
    chk("rej10_lat", lat, 1);
    chk("rej10_valid", center_valid, 0);
    chk("rej10_x", x_center, 512);

    // Mass exactly at threshold passes; y exactly 1023 is not saturated
    run_frame(35'd640, 35'd65472, 26'd64, -1, 71, lat, ovr_seen, busy_err);
    chk("min_lat", lat, 72);
    chk("min_valid", center_valid, 1);
    chk("min_x", x_center, 10);
    chk("min_y", y_center, 1023);

    // Full-width operands: (2^35-1)/(2^26-1) = 512 remainder 511
    run_frame('1, 35'd0, '1, -1, 71, lat, ovr_seen, busy_err);
    chk("wide_lat", lat, 72);
    chk("wide_x", x_center, 512);
    chk("wide_y", y_center, 0);

    // Overrun mid-division
    run_frame(35'd51200, 35'd30000, 26'd100, 30, 71, lat, ovr_seen, busy_err);
    chk("ovr30_pulse", ovr_seen, 1);
    chk("ovr30_lat", lat, 72);
    chk("ovr30_x", x_center, 512);
    chk("ovr30_y", y_center, 300);
    count_stb(90, stb_cnt);
    chk("ovr30_no_second", stb_cnt, 0);

    // Overrun on the DONE cycle
    run_frame(35'd1003, 35'd767, 26'd1000, 71, 71, lat, ovr_seen, busy_err);
    chk("ovrdone_pulse", ovr_seen, 1);
    chk("ovrdone_lat", lat, 72);
    chk("ovrdone_x", x_center, 1);
    count_stb(90, stb_cnt);
    chk("ovrdone_no_second", stb_cnt, 0);
    chk("ovrdone_idle", busy, 0);

    // Reset at cycle 40 of a division
    @(negedge clk);
    frame_start = 1'b1;
    x_total = 35'd51200;
    y_total = 35'd30000;
    mass_total = 26'd100;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      frame_start = 1'b0;
    end
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_x", x_center, 0);
    chk("mrst_y", y_center, 0);
    chk("mrst_valid", center_valid, 0);
    chk("mrst_stb", result_stb, 0);
    count_stb(90, stb_cnt);
    chk("mrst_no_stb", stb_cnt, 0);
    run_frame(35'd2000, 35'd1000, 26'd100, -1, 71, lat, ovr_seen, busy_err);
    chk("post_lat", lat, 72);
    chk("post_busy", busy_err, 0);
    chk("post_x", x_center, 20);
    chk("post_y", y_center, 10);
    chk("post_valid", center_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
